// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : seq_detect_pkg
//  Description: Shared types and sizing helpers for the serial pattern
//               detection controller and its matcher core.
//  Revision   : 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

  localparam int MAX_LEN_DEFAULT = 8;
  localparam int CNT_W_DEFAULT   = 8;

  // DRAIN is reserved; the controller never enters it deliberately.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Width needed to hold a pattern length of 0..max_len.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_match_core.sv
`default_nettype none
// ============================================================================
//  Module     : seq_match_core
//  Description: Bit-serial pattern matcher. Keeps a history shift register
//               and a fill count, compares the low len bits of the updated
//               history against the pattern, and handles overlap mode.
//               hit_o is combinational for the bit presented this cycle.
//  Revision   : 1.0 - initial release
// ============================================================================
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter  int MAX_LEN = MAX_LEN_DEFAULT,
  localparam int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bit_i,
  input  logic               bit_valid_i,
  input  logic               clear_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic               overlap_i,
  output logic               hit_o
);

  localparam logic [LEN_W:0] c_max_fill = (LEN_W+1)'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] w_hist_new;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W:0]     w_fill_inc;
  logic               w_hit;

  // Compare the shifted-in history against the length-masked pattern; the
  // fill gate stops cleared history bits from producing false matches.
  always_comb begin
    w_hist_new = {hist_q[MAX_LEN-2:0], bit_i};
    w_fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
    w_mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(len_i));
    end
    w_hit = bit_valid_i
         && (len_i != '0)
         && (w_fill_inc >= {1'b0, len_i})
         && (((w_hist_new ^ pattern_i) & w_mask) == '0);
  end

  assign hit_o = w_hit;

  // Next history/fill: non-overlap hits restart the fill so the next match
  // needs len fresh bits; otherwise fill saturates at MAX_LEN.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_valid_i) begin
      hist_d = w_hist_new;
      if (w_hit && !overlap_i) begin
        fill_d = '0;
      end else if (w_fill_inc > c_max_fill) begin
        fill_d = c_max_fill[LEN_W-1:0];
      end else begin
        fill_d = w_fill_inc[LEN_W-1:0];
      end
    end
  end

  // History and fill registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : seq_detect_ctrl
//  Description: Run-time configurable serial pattern detection controller.
//               Accepts bytes on a valid/ready stream, serializes them MSB
//               first into seq_match_core, counts matches and raises a
//               sticky interrupt at a programmable count.
//  Revision   : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter  int MAX_LEN = MAX_LEN_DEFAULT,
  parameter  int CNT_W   = CNT_W_DEFAULT,
  localparam int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               start,
  input  logic               stop,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               busy,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               irq,
  input  logic               irq_clr
);

  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);

  state_e             state_q;
  logic               in_ready_q;
  logic               busy_q;
  logic               stop_seen_q;
  logic [7:0]         byte_q;
  logic [2:0]         bit_idx_q;

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [CNT_W-1:0]   thresh_q;

  logic               z_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               irq_q;

  logic               w_len_legal;
  logic               w_run_start;
  logic               w_bit_valid;
  logic               w_bit;
  logic               w_hit;
  logic               w_cnt_max;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_irq_set;

  assign w_len_legal = (len_q != '0) && (len_q <= c_max_len);
  assign w_run_start = (state_q == ST_IDLE) && start && w_len_legal;
  assign w_bit_valid = (state_q == ST_SHIFT);
  assign w_bit       = byte_q[bit_idx_q];

  assign w_cnt_max = &cnt_q;
  assign w_cnt_inc = cnt_q + CNT_W'(1);
  // irq only fires on the increment that lands exactly on the threshold.
  assign w_irq_set = w_hit && !w_cnt_max && (thresh_q != '0) && (w_cnt_inc == thresh_q);

  seq_match_core #(
    .MAX_LEN (MAX_LEN)
  ) u_match (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_i       (w_bit),
    .bit_valid_i (w_bit_valid),
    .clear_i     (w_run_start),
    .len_i       (len_q),
    .pattern_i   (pattern_q),
    .overlap_i   (overlap_q),
    .hit_o       (w_hit)
  );

  // Control FSM with registered handshake/busy outputs, serializer and config latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      stop_seen_q <= 1'b0;
      byte_q      <= '0;
      bit_idx_q   <= '0;
      pattern_q   <= '0;
      len_q       <= '0;
      overlap_q   <= 1'b0;
      thresh_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_we) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
            thresh_q  <= cfg_thresh;
          end
          if (w_run_start) begin
            state_q     <= ST_WAIT;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            stop_seen_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (in_valid && in_ready_q) begin
            state_q     <= ST_SHIFT;
            in_ready_q  <= 1'b0;
            byte_q      <= in_data;
            bit_idx_q   <= 3'd7;
            stop_seen_q <= stop;
          end else if (stop) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (stop) begin
            stop_seen_q <= 1'b1;
          end
          if (bit_idx_q == 3'd0) begin
            if (stop_seen_q || stop) begin
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              stop_seen_q <= 1'b0;
            end else begin
              state_q    <= ST_WAIT;
              in_ready_q <= 1'b1;
            end
          end else begin
            bit_idx_q <= bit_idx_q - 3'd1;
          end
        end
        ST_DRAIN: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Match pulse, saturating counter and sticky interrupt (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q   <= 1'b0;
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      z_q <= w_hit;
      if (w_run_start) begin
        cnt_q <= '0;
      end else if (w_hit && !w_cnt_max) begin
        cnt_q <= w_cnt_inc;
      end
      if (w_irq_set) begin
        irq_q <= 1'b1;
      end else if (irq_clr) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign z         = z_q;
  assign match_cnt = cnt_q;
  assign irq       = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : tb_seq_detect_ctrl
//  Description: Self-checking bench for seq_detect_ctrl: a table of directed
//               single-run vectors plus hand-written multi-cycle sequences.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_thresh;
  logic       start;
  logic       stop;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       z;
  logic [7:0] match_cnt;
  logic       irq;
  logic       irq_clr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_thresh  (cfg_thresh),
    .start       (start),
    .stop        (stop),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .busy        (busy),
    .z           (z),
    .match_cnt   (match_cnt),
    .irq         (irq),
    .irq_clr     (irq_clr)
  );

  // One run: config, up to two bytes, expected z pulse map (bit k = z seen
  // in the cycle after processed bit k), final count and irq.
  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    logic        ov;
    logic [7:0]  thr;
    int          nb;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] exp_z;
    logic [7:0]  exp_cnt;
    logic        exp_irq;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] pat, input logic [3:0] len,
                           input logic ov, input logic [7:0] thr);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_thresh  = thr;
    cfg_we      = 1'b1;
    tick();
    cfg_we      = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(name, in_ready, 1);
  endtask

  // Hand one byte over and record z after each of its 8 shifted bits.
  task automatic send_byte(input logic [7:0] b, output logic [7:0] zm);
    wait_ready("in_ready_wait");
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    zm = '0;
    for (int j = 0; j < 8; j++) begin
      tick();
      zm[j] = z;
    end
  endtask

  task automatic stop_run(input string name);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check(name, busy, 0);
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    logic [15:0] zall;
    logic [7:0]  zm;
    clear_irq();
    configure(v.pat, v.len, v.ov, v.thr);
    start_run();
    zall = '0;
    for (int b = 0; b < v.nb; b++) begin
      send_byte((b == 0) ? v.b0 : v.b1, zm);
      zall[b*8 +: 8] = zm;
    end
    check($sformatf("v%0d_zmap", idx), zall, v.exp_z);
    check($sformatf("v%0d_cnt", idx), match_cnt, v.exp_cnt);
    check($sformatf("v%0d_irq", idx), irq, v.exp_irq);
    stop_run($sformatf("v%0d_busy_after_stop", idx));
  endtask

  initial begin
    vec_t       vecs [11];
    logic [7:0] zm;

    vecs[0]  = '{8'h0A, 4'd4, 1'b1, 8'd0, 1, 8'hAA, 8'h00, 16'h00A8, 8'd3, 1'b0};
    vecs[1]  = '{8'hFA, 4'd4, 1'b0, 8'd0, 1, 8'hAA, 8'h00, 16'h0088, 8'd2, 1'b0};
    vecs[2]  = '{8'h0A, 4'd4, 1'b1, 8'd0, 2, 8'h01, 8'h40, 16'h0400, 8'd1, 1'b0};
    vecs[3]  = '{8'h00, 4'd4, 1'b1, 8'd0, 1, 8'hFF, 8'h00, 16'h0000, 8'd0, 1'b0};
    vecs[4]  = '{8'h00, 4'd4, 1'b1, 8'd0, 1, 8'h0F, 8'h00, 16'h0008, 8'd1, 1'b0};
    vecs[5]  = '{8'h00, 4'd4, 1'b1, 8'd0, 1, 8'h00, 8'h00, 16'h00F8, 8'd5, 1'b0};
    vecs[6]  = '{8'h00, 4'd4, 1'b0, 8'd0, 1, 8'h00, 8'h00, 16'h0088, 8'd2, 1'b0};
    vecs[7]  = '{8'h5A, 4'd8, 1'b1, 8'd1, 2, 8'h05, 8'hA0, 16'h0800, 8'd1, 1'b1};
    vecs[8]  = '{8'h01, 4'd1, 1'b0, 8'd4, 1, 8'hA5, 8'h00, 16'h00A5, 8'd4, 1'b1};
    vecs[9]  = '{8'h0A, 4'd4, 1'b1, 8'd4, 1, 8'hAA, 8'h00, 16'h00A8, 8'd3, 1'b0};
    vecs[10] = '{8'h0A, 4'd4, 1'b1, 8'd2, 1, 8'hAA, 8'h00, 16'h00A8, 8'd3, 1'b1};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_thresh = '0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = '0; irq_clr = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_z", z, 0);
    check("rst_irq", irq, 0);
    check("rst_cnt", match_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Table-driven runs
    for (int i = 0; i < 11; i++) begin
      run_vector(vecs[i], i);
    end

    // Threshold irq: set on the 3rd pulse, same-cycle clear loses, later clear wins
    clear_irq();
    configure(8'h0A, 4'd4, 1'b1, 8'd3);
    start_run();
    wait_ready("t4_ready");
    in_valid = 1'b1; in_data = 8'hAA;
    tick();
    in_valid = 1'b0;
    for (int j = 0; j < 7; j++) begin
      tick();
      if (j == 5) check("t4_irq_before", irq, 0);
    end
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("t4_z3", z, 1);
    check("t4_irq_set_wins", irq, 1);
    check("t4_cnt", match_cnt, 3);
    clear_irq();
    check("t4_irq_cleared", irq, 0);
    stop_run("t4_busy_after_stop");

    // Config write during SHIFT is ignored; stop mid-byte finishes the byte
    configure(8'h0A, 4'd4, 1'b1, 8'd0);
    start_run();
    wait_ready("t5_ready");
    in_valid = 1'b1; in_data = 8'hAA;
    tick();
    in_valid = 1'b0;
    zm = '0;
    for (int j = 0; j < 8; j++) begin
      if (j == 2) begin
        cfg_we = 1'b1; cfg_pattern = 8'hFF; cfg_len = 4'd8; cfg_overlap = 1'b0; cfg_thresh = 8'd1;
      end
      if (j == 3) stop = 1'b1;
      tick();
      cfg_we = 1'b0;
      stop   = 1'b0;
      zm[j]  = z;
      if (j == 5) check("t5_busy_mid", busy, 1);
    end
    check("t5_zmap", zm, 8'hA8);
    check("t5_busy_idle", busy, 0);
    check("t5_ready_idle", in_ready, 0);
    check("t5_irq", irq, 0);
    start_run();
    send_byte(8'hAA, zm);
    check("t5_cfg_kept_zmap", zm, 8'hA8);
    stop_run("t5_busy_after_stop");

    // Illegal lengths are refused; stop in WAIT returns to IDLE
    configure(8'h0A, 4'd0, 1'b1, 8'd0);
    start_run();
    check("len0_busy", busy, 0);
    check("len0_ready", in_ready, 0);
    configure(8'h0A, 4'd9, 1'b1, 8'd0);
    start_run();
    check("len9_busy", busy, 0);
    configure(8'h0A, 4'd4, 1'b1, 8'd0);
    start_run();
    check("wait_busy", busy, 1);
    check("wait_ready", in_ready, 1);
    stop_run("wait_stop_busy");
    check("wait_stop_ready", in_ready, 0);

    // Counter saturation: len=1 pattern 0, 33 zero bytes -> 264 hits
    clear_irq();
    configure(8'h00, 4'd1, 1'b1, 8'd255);
    start_run();
    for (int b = 0; b < 33; b++) begin
      send_byte(8'h00, zm);
    end
    check("sat_cnt", match_cnt, 255);
    check("sat_irq", irq, 1);
    check("sat_zmap", zm, 8'hFF);
    stop_run("sat_busy_after_stop");

    // Asynchronous reset during the 4th SHIFT cycle of a second byte
    clear_irq();
    configure(8'h0A, 4'd4, 1'b1, 8'd1);
    start_run();
    send_byte(8'hAA, zm);
    wait_ready("t6_ready");
    in_valid = 1'b1; in_data = 8'hAA;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("t6_pre_cnt", match_cnt, 4);
    check("t6_pre_irq", irq, 1);
    check("t6_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_z", z, 0);
    check("t6_rst_irq", irq, 0);
    check("t6_rst_cnt", match_cnt, 0);
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_busy", busy, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_vector(vecs[0], 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
